// File: rtl/vga_pkg.sv
// Raster timing sets and helpers shared by the VGA timing generator and the
// renderer. A timing set bundles active/porch/sync lengths and sync polarity
// for both axes; helper functions derive line/frame totals and the minimum
// coordinate width that can count a whole line or frame.
package vga_pkg;

    typedef struct packed {
        int   h_active;
        int   h_fp;
        int   h_sync;
        int   h_bp;
        int   v_active;
        int   v_fp;
        int   v_sync;
        int   v_bp;
        logic h_pol;
        logic v_pol;
    } timing_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs.
    localparam timing_t VGA_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs.
    localparam timing_t SVGA_800x600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        h_pol: 1'b1, v_pol: 1'b1
    };

    function automatic int line_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input timing_t t);
        return line_total(t.h_active, t.h_fp, t.h_sync, t.h_bp);
    endfunction

    function automatic int v_total(input timing_t t);
        return line_total(t.v_active, t.v_fp, t.v_sync, t.v_bp);
    endfunction

    // Smallest coordinate width that can hold every hc/vc value of a set.
    function automatic int coord_width(input timing_t t);
        int m;
        m = (h_total(t) > v_total(t)) ? h_total(t) : v_total(t);
        return $clog2(m);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_delay.sv
// pix_delay: DEPTH-deep shift register of 3-bit words that advances only on
// pix_en. Used to align sync/video_on (or colour) with a pixel pipeline.
// DEPTH=0 is a plain wire.
//   clk, rst (async, active-high), pix_en : clocking and advance enable
//   d  [2:0] : input word
//   q  [2:0] : word delayed by DEPTH pix_en ticks (RST_VAL while filling)
module pix_delay #(
    parameter int         DEPTH   = 0,
    parameter logic [2:0] RST_VAL = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [2:0] d,
    output logic [2:0] q
);

    if (DEPTH == 0) begin : g_bypass
        assign q = d;
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst, pix_en};
    end else begin : g_shift
        logic [2:0] stage [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else if (pix_en) begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
//   clk, rst (async, active-high)
//   pix_en      : pixel tick, all state advances only when high
//   hsync/vsync : syncs at H_POL/V_POL, delayed by PIPE_DLY pix_en ticks
//   video_on    : active-area flag, delayed like the syncs
//   x, y        : coordinates of the pixel captured on the last pix_en
//   line_start  : one-clk pulse after capturing x==0
//   frame_start : one-clk pulse after capturing (0,0)
//   frame_cnt   : frames started since reset, wraps at 2^16
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_640x480_60.h_active,
    parameter int   H_FP     = VGA_640x480_60.h_fp,
    parameter int   H_SYNC   = VGA_640x480_60.h_sync,
    parameter int   H_BP     = VGA_640x480_60.h_bp,
    parameter int   V_ACTIVE = VGA_640x480_60.v_active,
    parameter int   V_FP     = VGA_640x480_60.v_fp,
    parameter int   V_SYNC   = VGA_640x480_60.v_sync,
    parameter int   V_BP     = VGA_640x480_60.v_bp,
    parameter logic H_POL    = VGA_640x480_60.h_pol,
    parameter logic V_POL    = VGA_640x480_60.v_pol,
    parameter int   PIPE_DLY = 0,
    parameter int   CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (((longint'(1) << CW) < longint'(H_TOTAL)) ||
        ((longint'(1) << CW) < longint'(V_TOTAL))) begin : g_bad_cw
        $error("vga_timing_gen: CW=%0d too small for %0dx%0d", CW, H_TOTAL, V_TOTAL);
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY=%0d outside 0..7", PIPE_DLY);
    end

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS   = CW'(V_ACTIVE);
    // Inclusive sync bounds so a zero back porch cannot overflow the end value.
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0] hc, vc;
    logic          h_act, v_act, vis, at_line, at_frame;
    logic          hs0, vs0, vid0;
    logic [2:0]    dly_q;

    // Decode of the pixel the counters currently hold.
    always_comb begin
        h_act    = (hc >= HS_BEG) && (hc <= HS_LAST);
        v_act    = (vc >= VS_BEG) && (vc <= VS_LAST);
        vis      = (hc < H_VIS) && (vc < V_VIS);
        at_line  = (hc == '0);
        at_frame = (hc == '0) && (vc == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc          <= '0;
            vc          <= '0;
            x           <= '0;
            y           <= '0;
            hs0         <= ~H_POL;
            vs0         <= ~V_POL;
            vid0        <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                // Line and frame wrap share this edge, so the period never drifts.
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + CW'(1);
                end else begin
                    hc <= hc + CW'(1);
                end
                // Stage 0 captures the pre-edge pixel; polarity applied here so
                // the delay line carries pin levels.
                x           <= hc;
                y           <= vc;
                hs0         <= h_act ? H_POL : ~H_POL;
                vs0         <= v_act ? V_POL : ~V_POL;
                vid0        <= vis;
                line_start  <= at_line;
                frame_start <= at_frame;
                if (at_frame) frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    pix_delay #(
        .DEPTH   (PIPE_DLY),
        .RST_VAL ({~H_POL, ~V_POL, 1'b0})
    ) u_pix_delay (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .d      ({hs0, vs0, vid0}),
        .q      (dly_q)
    );

    assign {hsync, vsync, video_on} = dly_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    localparam int NDUT = 5;
    localparam int EW   = 45;
    localparam int HS_B = 44;
    localparam int VS_B = 43;
    localparam int VID_B = 42;
    localparam int LS_B = 17;
    localparam int FS_B = 16;

    // 0: 640x480 defaults        1: small raster, no delay
    // 2: 640x480, delay 3, pos   3: SVGA 800x600  4: small, delay 2, pos
    localparam int P_HA [NDUT] = '{640, 16, 640, 800, 16};
    localparam int P_HF [NDUT] = '{16,  2,  16,  40,  2};
    localparam int P_HS [NDUT] = '{96,  3,  96,  128, 3};
    localparam int P_HB [NDUT] = '{48,  4,  48,  88,  4};
    localparam int P_VA [NDUT] = '{480, 6,  480, 600, 6};
    localparam int P_VF [NDUT] = '{10,  1,  10,  1,   1};
    localparam int P_VS [NDUT] = '{2,   2,  2,   4,   2};
    localparam int P_VB [NDUT] = '{33,  3,  33,  23,  3};
    localparam int P_HP [NDUT] = '{0,   0,  1,   1,   1};
    localparam int P_VP [NDUT] = '{0,   0,  1,   1,   1};
    localparam int P_D  [NDUT] = '{0,   0,  3,   0,   2};
    localparam int P_CW [NDUT] = '{10,  5,  10,  11,  5};

    logic clk, rst, pix_en;
    logic [EW-1:0] obs [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic hs, vs, vid, ls, fs;
        logic [P_CW[g]-1:0] gx, gy;
        logic [15:0] cnt;
        vga_timing_gen #(
            .H_ACTIVE(P_HA[g]), .H_FP(P_HF[g]), .H_SYNC(P_HS[g]), .H_BP(P_HB[g]),
            .V_ACTIVE(P_VA[g]), .V_FP(P_VF[g]), .V_SYNC(P_VS[g]), .V_BP(P_VB[g]),
            .H_POL(1'(P_HP[g])), .V_POL(1'(P_VP[g])),
            .PIPE_DLY(P_D[g]), .CW(P_CW[g])
        ) u_dut (
            .clk(clk), .rst(rst), .pix_en(pix_en),
            .hsync(hs), .vsync(vs), .video_on(vid),
            .x(gx), .y(gy),
            .line_start(ls), .frame_start(fs), .frame_cnt(cnt)
        );
        assign obs[g] = {hs, vs, vid, 12'(gx), 12'(gy), ls, fs, cnt};
    end

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    longint n = 0;              // pix_en edges since reset
    logic [EW-1:0] exp_q[$];
    bit rec_on = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: outputs after n pix_en edges, computed from the tick count.
    function automatic logic [EW-1:0] exp_word(input int i, input longint cnt_n, input logic en);
        longint ht, vt, f, p, q;
        int xx, yy, qx, qy;
        logic hp, vp, hs, vs, vid, ls, fs;
        logic [15:0] fc;
        hp = 1'(P_HP[i]);
        vp = 1'(P_VP[i]);
        ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
        vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
        f  = ht * vt;
        hs = ~hp; vs = ~vp; vid = 1'b0;
        xx = 0; yy = 0; ls = 1'b0; fs = 1'b0; fc = '0;
        if (cnt_n > 0) begin
            p  = (cnt_n - 1) % f;
            xx = int'(p % ht);
            yy = int'(p / ht);
            ls = en && (xx == 0);
            fs = ls && (yy == 0);
            fc = 16'((cnt_n - 1) / f + 1);
            q  = cnt_n - 1 - P_D[i];
            if (q >= 0) begin
                q  = q % f;
                qx = int'(q % ht);
                qy = int'(q / ht);
                if (qx >= P_HA[i] + P_HF[i] && qx < P_HA[i] + P_HF[i] + P_HS[i]) hs = hp;
                if (qy >= P_VA[i] + P_VF[i] && qy < P_VA[i] + P_VF[i] + P_VS[i]) vs = vp;
                vid = (qx < P_HA[i]) && (qy < P_VA[i]);
            end
        end
        return {hs, vs, vid, 12'(xx), 12'(yy), ls, fs, fc};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic en);
        @(negedge clk);
        pix_en = en;
        if (en) n++;
        for (int i = 0; i < NDUT; i++) exp_q.push_back(exp_word(i, n, en));
    endtask

    // ---------------- event recording ----------------
    logic [EW-1:0] prev [NDUT];
    longint d0_fall_n = 0;
    int d0_fall_x[$], d0_w[$], d2_rise_x[$], d2_von_x[$], d2_voff_x[$], d3_wrap_px[$];
    longint d3_rise_n[$], fs1_n[$];
    int fs1_cnt[$];
    int vid1 = 0, vslo1 = 0, hslo1 = 0;

    task automatic record_events();
        if (prev[0][HS_B] && !obs[0][HS_B]) begin
            d0_fall_x.push_back(int'(obs[0][41:30]));
            d0_fall_n = n;
        end
        if (!prev[0][HS_B] && obs[0][HS_B]) d0_w.push_back(int'(n - d0_fall_n));
        if (obs[1][FS_B]) begin
            fs1_n.push_back(n);
            fs1_cnt.push_back(int'(obs[1][15:0]));
        end
        if (n >= 1 && n <= 300) begin
            if (obs[1][VID_B]) vid1++;
            if (!obs[1][VS_B]) vslo1++;
            if (!obs[1][HS_B]) hslo1++;
        end
        if (!prev[2][HS_B] && obs[2][HS_B]) d2_rise_x.push_back(int'(obs[2][41:30]));
        if (!prev[2][VID_B] && obs[2][VID_B]) d2_von_x.push_back(int'(obs[2][41:30]));
        if (prev[2][VID_B] && !obs[2][VID_B]) d2_voff_x.push_back(int'(obs[2][41:30]));
        if (!prev[3][HS_B] && obs[3][HS_B]) d3_rise_n.push_back(n);
        if (obs[3][LS_B] && n > 1) d3_wrap_px.push_back(int'(prev[3][41:30]));
        for (int i = 0; i < NDUT; i++) prev[i] = obs[i];
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin : sb_mon
        logic [EW-1:0] w;
        #1;
        if (exp_q.size() >= NDUT) begin
            for (int i = 0; i < NDUT; i++) begin
                w = exp_q.pop_front();
                check($sformatf("dut%0d_out_n%0d", i, n), 64'(obs[i]), 64'(w));
            end
            if (pix_en && rec_on) record_events();
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        pix_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < NDUT; i++)
            check($sformatf("reset_dut%0d", i), 64'(obs[i]), 64'(exp_word(i, 0, 1'b0)));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NDUT; i++) prev[i] = obs[i];
        rec_on = 1;

        // Phase A: pix_en every 4th clk.
        for (int k = 0; k < 700; k++) begin
            drive(1'b1);
            repeat (3) drive(1'b0);
        end

        // Phase B: pix_en tied high, with a 50-clk stall at x=300 on dut0.
        while (((n - 1) % 800) != 300) drive(1'b1);
        repeat (50) drive(1'b0);
        @(posedge clk); #2;
        check("stall_x", 64'(obs[0][41:30]), 64'd300);
        check("stall_ls", 64'(obs[0][LS_B]), 64'd0);
        check("stall_cnt", 64'(obs[0][15:0]), 64'd1);
        drive(1'b1);
        @(posedge clk); #2;
        check("resume_x", 64'(obs[0][41:30]), 64'd301);
        repeat (2500) drive(1'b1);
        rec_on = 0;

        // Phase C: reset while dut1 sits inside both syncs.
        while (((n - 1) % 300) != 194) drive(1'b1);
        @(posedge clk); #2;
        check("pre_rst_hs", 64'(obs[1][HS_B]), 64'd0);
        check("pre_rst_vs", 64'(obs[1][VS_B]), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        pix_en = 1'b0;
        n = 0;
        #1;
        for (int i = 0; i < NDUT; i++)
            check($sformatf("midrst_dut%0d", i), 64'(obs[i]), 64'(exp_word(i, 0, 1'b0)));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(1'b1);
        @(posedge clk); #2;
        check("rel_fs", 64'(obs[1][FS_B]), 64'd1);
        check("rel_ls", 64'(obs[1][LS_B]), 64'd1);
        check("rel_cnt", 64'(obs[1][15:0]), 64'd1);
        for (int k = 0; k < 320; k++) drive(1'($urandom_range(0, 1)));
        drive(1'b0);
        @(posedge clk); #2;
        check("q_empty", 64'(exp_q.size()), 64'd0);

        // Aggregate timing checks.
        check("fs1_pulses", 64'(fs1_n.size() >= 3), 64'd1);
        if (fs1_n.size() >= 3) begin
            check("fs1_first_n", 64'(fs1_n[0]), 64'd1);
            check("fs1_gap0", 64'(fs1_n[1] - fs1_n[0]), 64'd300);
            check("fs1_gap1", 64'(fs1_n[2] - fs1_n[1]), 64'd300);
            check("fs1_cnt0", 64'(fs1_cnt[0]), 64'd1);
            check("fs1_cnt1", 64'(fs1_cnt[1]), 64'd2);
        end
        check("d1_vid_frame", 64'(vid1), 64'd96);
        check("d1_vs_lo", 64'(vslo1), 64'd50);
        check("d1_hs_lo", 64'(hslo1), 64'd36);
        check("d0_falls", 64'(d0_fall_x.size() >= 3), 64'd1);
        foreach (d0_fall_x[k]) check("d0_fall_x", 64'(d0_fall_x[k]), 64'd656);
        check("d0_widths", 64'(d0_w.size() >= 3), 64'd1);
        foreach (d0_w[k]) check("d0_hs_width", 64'(d0_w[k]), 64'd96);
        check("d2_rises", 64'(d2_rise_x.size() >= 3), 64'd1);
        foreach (d2_rise_x[k]) check("d2_hs_rise_x", 64'(d2_rise_x[k]), 64'd659);
        check("d2_von_n", 64'(d2_von_x.size() >= 3), 64'd1);
        foreach (d2_von_x[k]) check("d2_von_x", 64'(d2_von_x[k]), 64'd3);
        check("d2_voff_n", 64'(d2_voff_x.size() >= 3), 64'd1);
        foreach (d2_voff_x[k]) check("d2_voff_x", 64'(d2_voff_x[k]), 64'd643);
        check("d3_rises", 64'(d3_rise_n.size() >= 3), 64'd1);
        if (d3_rise_n.size() >= 3) begin
            check("d3_hs_gap0", 64'(d3_rise_n[1] - d3_rise_n[0]), 64'd1056);
            check("d3_hs_gap1", 64'(d3_rise_n[2] - d3_rise_n[1]), 64'd1056);
        end
        check("d3_wraps", 64'(d3_wrap_px.size() >= 3), 64'd1);
        foreach (d3_wrap_px[k]) check("d3_last_x", 64'(d3_wrap_px[k]), 64'd1055);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
